// File: rtl/state_change_recorder_pkg.sv
// Shared definitions for the state-change recorder: record field offsets
// and a constant-evaluable clog2 helper used for pointer/count widths.
package state_change_recorder_pkg;

  localparam int DEF_BITS    = 8;
  localparam int DEF_DEPTH   = 16;
  localparam int DEF_TS_BITS = 16;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Record layout, MSB first: {prev, cur, ts}.
  function automatic int prev_msb(input int bits, input int ts_bits);
    return 2 * bits + ts_bits - 1;
  endfunction

  function automatic int prev_lsb(input int bits, input int ts_bits);
    return bits + ts_bits;
  endfunction

  function automatic int cur_msb(input int bits, input int ts_bits);
    return bits + ts_bits - 1;
  endfunction

  function automatic int cur_lsb(input int bits, input int ts_bits);
    return ts_bits + 0 * bits;
  endfunction

  function automatic int ts_msb(input int bits, input int ts_bits);
    return ts_bits - 1 + 0 * bits;
  endfunction

  function automatic int ts_lsb(input int bits, input int ts_bits);
    return 0 * (bits + ts_bits);
  endfunction

endpackage

// File: rtl/state_rec_fifo.sv
// First-word-fall-through ring buffer holding state-change records.
// A push while full is only accepted when a pop happens in the same cycle.
module state_rec_fifo
  import state_change_recorder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [clog2(DEPTH):0]      count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_ok  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign push_ok = push && (!full || pop);
  assign count   = cnt;
  // Output forced to zero while empty so the post-reset value is defined.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage array write port; no reset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/state_change_recorder.sv
// Timestamps transitions of a debug state vector and queues
// {previous, new, timestamp} records for firmware to drain oldest-first.
module state_change_recorder
  import state_change_recorder_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TS_BITS = DEF_TS_BITS
) (
  input  logic                      iClk,
  input  logic                      iRst_n,
  input  logic                      iClear,
  input  logic                      iEnable,
  input  logic                      iFreeze,
  input  logic                      iTick,
  input  logic [BITS-1:0]           iDbgSt,
  input  logic                      iRdReq,
  output logic [2*BITS+TS_BITS-1:0] oRdData,
  output logic                      oEmpty,
  output logic                      oFull,
  output logic [clog2(DEPTH):0]     oCount,
  output logic                      oOverflow
);

  localparam int REC_W    = 2 * BITS + TS_BITS;
  localparam int PREV_MSB = prev_msb(BITS, TS_BITS);
  localparam int PREV_LSB = prev_lsb(BITS, TS_BITS);
  localparam int CUR_MSB  = cur_msb(BITS, TS_BITS);
  localparam int CUR_LSB  = cur_lsb(BITS, TS_BITS);
  localparam int TS_MSB   = ts_msb(BITS, TS_BITS);
  localparam int TS_LSB   = ts_lsb(BITS, TS_BITS);

  logic [BITS-1:0]    last;
  logic               armed;
  logic [TS_BITS-1:0] ts_cnt;
  logic               overflow;
  logic               clear;
  logic               change;
  logic               push_req;
  logic [REC_W-1:0]   record;

  assign clear    = !iClear;
  assign change   = armed && (iDbgSt != last);
  assign push_req = change && iEnable && !iFreeze && !clear;

  // Assemble the record from the baseline, the new state and the current stamp.
  always_comb begin
    record                   = '0;
    record[PREV_MSB:PREV_LSB] = last;
    record[CUR_MSB:CUR_LSB]   = iDbgSt;
    record[TS_MSB:TS_LSB]     = ts_cnt;
  end

  // Baseline tracking: first armed cycle loads it, frozen cycles hold it.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      last  <= '0;
      armed <= 1'b0;
    end else if (clear) begin
      armed <= 1'b0;
    end else if (!armed) begin
      last  <= iDbgSt;
      armed <= 1'b1;
    end else if (change && !iFreeze) begin
      last  <= iDbgSt;
    end
  end

  // Free-running timestamp advanced by the external tick strobe.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)    ts_cnt <= '0;
    else if (clear) ts_cnt <= '0;
    else if (iTick) ts_cnt <= ts_cnt + TS_BITS'(1);
  end

  // Sticky overflow: a record was dropped because no slot could be freed.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                             overflow <= 1'b0;
    else if (clear)                          overflow <= 1'b0;
    else if (push_req && oFull && !iRdReq)   overflow <= 1'b1;
  end

  assign oOverflow = overflow;

  state_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (iClk),
    .rst_n (iRst_n),
    .clr   (clear),
    .push  (push_req),
    .pop   (iRdReq && !clear),
    .wdata (record),
    .rdata (oRdData),
    .count (oCount),
    .full  (oFull),
    .empty (oEmpty)
  );

endmodule

// File: doc/state_change_recorder.md
# state_change_recorder

Downstream consumer of a state-change source for power/sequencing debug. Watches a debug state vector, timestamps every transition and stores {previous state, new state, timestamp} records in a small circular buffer. Firmware drains the buffer oldest-first over a pop handshake. Capture can be frozen after a fault so the first failing sequence is preserved.

## Interface
- BITS, 8: width of the monitored state vector.
- DEPTH, 16: record entries; power of two, ≥2.
- TS_BITS, 16: timestamp width.
- iClk  in  1  system clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- iClear  in  1  synchronous clear, active-low: empties buffer, clears oOverflow, re-arms baseline.
- iEnable  in  1  capture enable; while low, no records are pushed, but the baseline still tracks iDbgSt.
- iFreeze  in  1  level; while high, no records are pushed and the baseline is held.
- iTick  in  1  timestamp increment strobe, one iClk wide (e.g. 1 ms tick).
- iDbgSt  in  BITS  monitored state, already synchronous to iClk.
- iRdReq  in  1  pop strobe for the oldest record.
- oRdData  out  2*BITS+TS_BITS  oldest record {prev, cur, ts}, prev in MSBs; first-word-fall-through.
- oEmpty  out  1  no records stored.
- oFull  out  1  DEPTH records stored.
- oCount  out  clog2(DEPTH)+1  records stored.
- oOverflow  out  1  sticky: a change was dropped because the buffer was full.

## Operation
- Baseline register `last` holds the last accepted state. Flag `armed` is 0 after reset or clear.
  - First cycle with `armed`=0: load `last`<=iDbgSt, set `armed`, push nothing.
- Change detection: `armed` && iDbgSt != `last`.
  - If iEnable=1 and iFreeze=0: push {`last`, iDbgSt, ts_cnt}, then `last`<=iDbgSt.
  - If iEnable=0 (iFreeze=0): update `last`, no push.
  - If iFreeze=1: no push, `last` held. The first change after unfreeze is recorded against the pre-freeze state.
- Timestamp ts_cnt:
  - Increments on iTick and wraps modulo 2^TS_BITS.
  - Reset and clear set it to 0.
  - A record captures the pre-increment value in the cycle a push and iTick coincide.
- Full, push without pop: record dropped, oOverflow<=1, buffer unchanged (oldest data kept).
- Full, push with pop in the same cycle: both happen, count unchanged, no overflow.
- Empty with iRdReq: ignored, no pointer movement.
- Push and pop on a non-empty, non-full buffer: count unchanged.
- Pointers are clog2(DEPTH) bits and wrap naturally. Count is tracked separately.
- iClear low has priority over push and pop in that cycle.

## Timing
- Reset values:
  - oEmpty=1, oFull=0, oCount=0, oOverflow=0, oRdData=0.
  - ts_cnt=0, `armed`=0, pointers=0.
- Push latency: a change sampled at edge N gives oEmpty=0, oCount+1 and a valid oRdData after edge N (visible in cycle N+1).
- Pop: iRdReq sampled at edge N advances the read pointer; oRdData shows the next record in cycle N+1. oRdData is don't-care when oEmpty=1, except that it is 0 after reset.
- Back-to-back changes on consecutive cycles each produce one record; no cycle is lost.
- Asynchronous reset mid-operation discards all records immediately. The next accepted state after release is the baseline, not a record.

## Structure
- A shared include holds:
  - the record field offset macros (PREV_MSB/LSB, CUR_MSB/LSB, TS_MSB/LSB) as functions of BITS/TS_BITS;
  - a clog2 helper.
- Sub-module `state_rec_fifo`:
  - parameterized synchronous FWFT ring buffer (WIDTH, DEPTH);
  - push/pop/count/full/empty, register array storage.
- The top level holds the baseline, change detect, timestamp counter, overflow flag and freeze/enable gating.

## Test plan
- Reset, hold iDbgSt=8'h03, then step to 8'h05 at tick count 2 with iEnable=1.
  - Expect oEmpty=1 until the step.
  - Then one record {03, 05, 0002}, oCount=1.
  - Pop, then oEmpty=1.
- DEPTH=16 and 17 distinct changes without pops:
  - oFull=1 after 16 changes, oOverflow=1 on the 17th.
  - Reading returns the first 16 changes in order; the 17th is absent.
- Full buffer with a change and iRdReq in the same cycle:
  - oCount stays 16, oOverflow stays 0.
  - Reading returns records 2..17.
- iFreeze=1, state goes 01→02→07, then iFreeze=0 and state goes to 09:
  - Exactly one record, {01, 09, ts}.
- iEnable=0 during 01→04, then iEnable=1 and 04→06:
  - Exactly one record, {04, 06, ts}.
- Pulse iClear low with 5 records stored and oOverflow=1:
  - Next cycle oCount=0, oOverflow=0, ts_cnt=0.
  - The next state change sets the baseline only, no record.
